jogador_ctrl: RTL

JOGADOR_CTRL -- requirements
Module: jogador_ctrl

---
 rtl/jogo_pkg.sv | 44 ++++
 rtl/step_timer.sv | 28 ++
 rtl/jogador_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// Shared game definitions: screen size, heading and FSM encodings, pixel colour payload.
package jogo_pkg;

   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;
   localparam int unsigned CALC_W   = 11;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_UP    = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PAUSED = 2'd1,
      ST_DEAD   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      TURN_NONE = 2'd0,
      TURN_CW   = 2'd1,
      TURN_ACW  = 2'd2
   } turn_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // Heading after applying a turn, modulo four.
   function automatic dir_t turn_dir(input dir_t d, input turn_t t);
      logic [1:0] r;
      r = d;
      if (t == TURN_CW)
         r = d + 2'd1;
      else if (t == TURN_ACW)
         r = d - 2'd1;
      return dir_t'(r);
   endfunction

endpackage

// File: rtl/step_timer.sv
// Movement pacing counter: counts 0..STEP_TICKS-1 while enabled and flags the last count.
module step_timer #(
   parameter int unsigned STEP_TICKS = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic tick_c
);

   localparam int unsigned CNT_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_TICKS - 1);

   logic [CNT_W-1:0] cnt;

   assign tick_c = enable && !clear && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable)
         cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
   end

endmodule

// File: rtl/jogador_ctrl.sv
// Player controller: steps a square one cell per timer period, turns on key presses,
// dies or wraps at the screen border, and paints the square into the pixel stream.
module jogador_ctrl #(
   parameter int unsigned CELL       = 8,
   parameter int unsigned SCREEN_W   = jogo_pkg::SCREEN_W,
   parameter int unsigned SCREEN_H   = jogo_pkg::SCREEN_H,
   parameter int unsigned START_X    = 216,
   parameter int unsigned START_Y    = 232,
   parameter int unsigned START_DIR  = 0,
   parameter int unsigned STEP_TICKS = 1000000,
   parameter int unsigned WRAP       = 0,
   parameter logic [23:0] COLOR      = 24'hFFFF00,
   parameter logic [23:0] DEAD_COLOR = 24'hFF0000
) (
   input  logic       VGA_CLK,
   input  logic       reset_n,
   input  logic       reiniciar,
   input  logic       pausa,
   input  logic [1:0] KEY,
   input  logic [9:0] next_x,
   input  logic [9:0] next_y,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic [1:0] dir,
   output logic       step,
   output logic       alive,
   output logic       hit,
   output logic [7:0] OUT_R,
   output logic [7:0] OUT_G,
   output logic [7:0] OUT_B
);
   import jogo_pkg::*;

   localparam logic [CALC_W-1:0] MAX_X  = CALC_W'(SCREEN_W - CELL);
   localparam logic [CALC_W-1:0] MAX_Y  = CALC_W'(SCREEN_H - CELL);
   localparam logic [CALC_W-1:0] CELL_W = CALC_W'(CELL);
   localparam logic              WRAP_EN = (WRAP != 0);

   state_t            state, state_next;
   dir_t              dir_q, dir_new_c;
   turn_t             pending;
   logic [1:0]        key_q, key_fall_c;
   logic              tick_c;
   logic [CALC_W-1:0] mx_c, my_c;
   logic [9:0]        nx_c, ny_c;
   logic              out_x_c, out_y_c, move_ok_c;
   rgb_t              colour_c;

   step_timer #(.STEP_TICKS(STEP_TICKS)) u_step_timer (
      .clk    (VGA_CLK),
      .rst_n  (reset_n),
      .enable (state == ST_RUN),
      .clear  (reiniciar),
      .tick_c (tick_c)
   );

   assign key_fall_c = key_q & ~KEY;
   assign dir        = dir_q;

   // Candidate move: turn first, then step; 11-bit math exposes underflow past zero.
   always_comb begin
      dir_new_c = turn_dir(dir_q, pending);
      mx_c      = {1'b0, pos_x};
      my_c      = {1'b0, pos_y};
      case (dir_new_c)
         DIR_RIGHT: mx_c = {1'b0, pos_x} + CELL_W;
         DIR_LEFT:  mx_c = {1'b0, pos_x} - CELL_W;
         DIR_DOWN:  my_c = {1'b0, pos_y} + CELL_W;
         default:   my_c = {1'b0, pos_y} - CELL_W;
      endcase
      out_x_c   = (mx_c > MAX_X);
      out_y_c   = (my_c > MAX_Y);
      move_ok_c = !(out_x_c || out_y_c) || WRAP_EN;
      nx_c      = mx_c[9:0];
      ny_c      = my_c[9:0];
      if (out_x_c)
         nx_c = (dir_new_c == DIR_RIGHT) ? 10'd0 : MAX_X[9:0];
      if (out_y_c)
         ny_c = (dir_new_c == DIR_DOWN) ? 10'd0 : MAX_Y[9:0];
   end

   always_ff @(posedge VGA_CLK or negedge reset_n) begin
      if (!reset_n)
         state <= ST_RUN;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_RUN: begin
            if (tick_c && !move_ok_c)
               state_next = ST_DEAD;
            else if (pausa)
               state_next = ST_PAUSED;
         end
         ST_PAUSED: begin
            if (!pausa)
               state_next = ST_RUN;
         end
         ST_DEAD: state_next = ST_DEAD;
         default: state_next = ST_RUN;
      endcase
      if (reiniciar)
         state_next = ST_RUN;
   end

   // Position, heading and turn arming; a key edge landing on a step is kept for the next one.
   always_ff @(posedge VGA_CLK or negedge reset_n) begin
      if (!reset_n) begin
         pos_x   <= 10'(START_X);
         pos_y   <= 10'(START_Y);
         dir_q   <= dir_t'(2'(START_DIR));
         pending <= TURN_NONE;
         key_q   <= 2'b11;
         step    <= 1'b0;
         alive   <= 1'b1;
      end else begin
         key_q <= KEY;
         step  <= 1'b0;
         alive <= (state_next != ST_DEAD);
         if (reiniciar) begin
            pos_x   <= 10'(START_X);
            pos_y   <= 10'(START_Y);
            dir_q   <= dir_t'(2'(START_DIR));
            pending <= TURN_NONE;
         end else begin
            if (tick_c) begin
               dir_q   <= dir_new_c;
               pending <= TURN_NONE;
               if (move_ok_c) begin
                  pos_x <= nx_c;
                  pos_y <= ny_c;
                  step  <= 1'b1;
               end
            end
            if (state == ST_RUN) begin
               if (key_fall_c == 2'b11)
                  pending <= TURN_NONE;
               else if (key_fall_c[0])
                  pending <= TURN_CW;
               else if (key_fall_c[1])
                  pending <= TURN_ACW;
            end
         end
      end
   end

   assign hit = ({1'b0, next_x} >= {1'b0, pos_x}) && ({1'b0, next_x} < ({1'b0, pos_x} + CELL_W)) &&
                ({1'b0, next_y} >= {1'b0, pos_y}) && ({1'b0, next_y} < ({1'b0, pos_y} + CELL_W));

   always_comb begin
      colour_c = '0;
      if (hit)
         colour_c = alive ? rgb_t'(COLOR) : rgb_t'(DEAD_COLOR);
   end

   assign OUT_R = colour_c.r;
   assign OUT_G = colour_c.g;
   assign OUT_B = colour_c.b;

endmodule
